// File: rtl/amp_frame_src.sv
// amp_frame_src: ping-pong buffers LEN-bin amplitude frames and replays each as a sop/eop framed stream
// ports: clk/rst_n (async active-low); sink_valid/sink_data/sink_ready accept samples;
//        source_valid/source_ready/source_data/source_sop/source_eop present frames; frame_cnt counts frames sent
module amp_frame_src #(
   parameter int DW  = 24,
   parameter int LEN = 256,
   parameter int AW  = 8,
   parameter int GAP = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sink_valid,
   input  logic [DW-1:0] sink_data,
   output logic          sink_ready,
   input  logic          source_ready,
   output logic          source_valid,
   output logic [DW-1:0] source_data,
   output logic          source_sop,
   output logic          source_eop,
   output logic [15:0]   frame_cnt
);
   localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_GAP} state_t;
   state_t state;
   logic [DW-1:0] mem [0:2*LEN-1];
   logic [1:0] full;
   logic wr_bank, rd_bank;
   logic [AW-1:0] wr_idx, rd_idx, rd_nxt;
   logic [GW-1:0] gap_cnt;
   logic wr_fire, wr_last, rd_done;
   assign sink_ready = !full[wr_bank];
   assign wr_fire = sink_valid && sink_ready;
   assign wr_last = wr_fire && wr_idx == AW'(LEN-1);
   assign rd_done = state == S_STREAM && source_ready && source_eop;
   assign rd_nxt = rd_idx + 1'b1;
   always_ff @(posedge clk)
      if (wr_fire) mem[{wr_bank, wr_idx}] <= sink_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         full    <= '0;
         wr_bank <= 1'b0;
         wr_idx  <= '0;
      end else begin
         wr_idx  <= wr_fire ? wr_idx + 1'b1 : wr_idx;
         wr_bank <= wr_bank ^ wr_last;
         full    <= (full | ({wr_bank, !wr_bank} & {2{wr_last}})) & ~({rd_bank, !rd_bank} & {2{rd_done}});
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= S_IDLE;
         rd_bank      <= 1'b0;
         rd_idx       <= '0;
         gap_cnt      <= '0;
         source_valid <= 1'b0;
         source_data  <= '0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               rd_idx <= '0;
               if (full[rd_bank]) state <= S_PRIME;
            end
            S_PRIME: begin
               source_data  <= mem[{rd_bank, rd_idx}];
               source_valid <= 1'b1;
               source_sop   <= 1'b1;
               source_eop   <= 1'b0;
               state        <= S_STREAM;
            end
            S_STREAM:
               if (source_ready) begin
                  if (source_eop) begin
                     source_valid <= 1'b0;
                     source_sop   <= 1'b0;
                     source_eop   <= 1'b0;
                     rd_bank      <= !rd_bank;
                     frame_cnt    <= frame_cnt + 1'b1;
                     gap_cnt      <= '0;
                     state        <= GAP == 0 ? S_IDLE : S_GAP;
                  end else begin
                     rd_idx      <= rd_nxt;
                     source_data <= mem[{rd_bank, rd_nxt}];
                     source_sop  <= 1'b0;
                     source_eop  <= rd_nxt == AW'(LEN-1);
                  end
               end
            S_GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == GW'(GAP-1)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_amp_frame_src.sv
// tb_amp_frame_src: directed plus random stimulus against a frame-level scoreboard of amp_frame_src
module tb_amp_frame_src;
   localparam int DW = 24, LEN = 8, AW = 3, GAP = 2;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic sv = 0, rdy = 0, sr, vld, sop, eop;
   logic [DW-1:0] sd = '0, dat;
   logic [15:0] fc;
   logic sv1 = 0, rdy1 = 0, sr1, vld1, sop1, eop1;
   logic [DW-1:0] sd1 = '0, dat1;
   logic [15:0] fc1;
   int n_cmp = 0, n_err = 0;
   amp_frame_src #(.DW(DW), .LEN(LEN), .AW(AW), .GAP(GAP)) u0 (
      .clk(clk), .rst_n(rst_n), .sink_valid(sv), .sink_data(sd), .sink_ready(sr),
      .source_ready(rdy), .source_valid(vld), .source_data(dat), .source_sop(sop),
      .source_eop(eop), .frame_cnt(fc));
   amp_frame_src #(.DW(DW), .LEN(LEN), .AW(AW), .GAP(0)) u1 (
      .clk(clk), .rst_n(rst_n), .sink_valid(sv1), .sink_data(sd1), .sink_ready(sr1),
      .source_ready(rdy1), .source_valid(vld1), .source_data(dat1), .source_sop(sop1),
      .source_eop(eop1), .frame_cnt(fc1));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   logic [DW-1:0] q[$];
   int wr_cnt = 0, sent = 0, bin = 0, idle = 0;
   bit gapping = 0, nxt_full = 0, prev_hold = 0, just_eop;
   logic [DW+1:0] prev = '0;
   always @(negedge clk)
      if (!rst_n) begin
         q.delete();
         wr_cnt = 0; sent = 0; bin = 0; gapping = 0; prev_hold = 0;
      end else begin
         just_eop = 0;
         chk("sink_ready", {31'd0, sr}, {31'd0, (wr_cnt / LEN - sent) < 2});
         chk("frame_cnt", {16'd0, fc}, {16'd0, 16'(sent)});
         if (prev_hold) begin
            chk("hold_valid", {31'd0, vld}, 1);
            chk("hold_beat", 32'({sop, eop, dat}), 32'(prev));
         end
         if (gapping && vld) begin
            if (nxt_full) chk("gap_exact", idle, GAP + 2);
            else chk("gap_min", {31'd0, idle >= GAP + 2}, 1);
            gapping = 0;
         end else if (gapping) idle++;
         if (vld && rdy) begin
            if (q.size() == 0) chk("stale_beat", 1, 0);
            else chk("data", 32'(dat), 32'(q.pop_front()));
            chk("sop", {31'd0, sop}, {31'd0, bin == 0});
            chk("eop", {31'd0, eop}, {31'd0, bin == LEN - 1});
            bin = (bin + 1) % LEN;
            if (bin == 0) begin
               sent++; gapping = 1; idle = 0; just_eop = 1;
            end
         end
         prev_hold = vld && !rdy;
         prev = {sop, eop, dat};
         if (sv && sr) begin
            q.push_back(sd);
            wr_cnt++;
         end
         if (just_eop) nxt_full = (wr_cnt / LEN - sent) >= 1;
      end
   task automatic put(input logic [DW-1:0] d);
      int t = 0;
      sv = 1; sd = d;
      while (!sr && t < 300) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 300) chk("put_timeout", 0, 1);
      @(posedge clk); #1;
      sv = 0;
   endtask
   task automatic wait_fc(input int n);
      int t = 0;
      while (fc != 16'(n) && t < 600) begin
         @(posedge clk); #1; t++;
      end
      chk("frame_cnt_reach", {16'd0, fc}, n);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, vld}, 0);
      chk("rst_data", 32'(dat), 0);
      chk("rst_sopeop", {30'd0, sop, eop}, 0);
      chk("rst_fc", {16'd0, fc}, 0);
      rst_n = 1;
      chk("rst_sink_ready", {31'd0, sr}, 1);
      rdy = 1;
      for (int k = 1; k <= 8; k++) put(DW'(k));
      chk("lat_e0", {31'd0, vld}, 0);
      @(posedge clk); #1;
      chk("lat_e1", {31'd0, vld}, 0);
      @(posedge clk); #1;
      chk("lat_e2", {31'd0, vld}, 1);
      chk("lat_sop", {31'd0, sop}, 1);
      chk("lat_data", 32'(dat), 1);
      wait_fc(1);
      repeat (6) @(posedge clk);
      #1;
      fork
         for (int k = 11; k <= 18; k++) put(DW'(k));
         for (int i = 0; i < 60; i++) begin
            rdy = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clk); #1;
         end
      join
      rdy = 1;
      wait_fc(2);
      rdy = 0;
      for (int k = 101; k <= 116; k++) put(DW'(k));
      chk("both_full", {31'd0, sr}, 0);
      rdy = 1;
      t = 0;
      while (!(vld && eop) && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("eop_seen", {31'd0, vld && eop}, 1);
      chk("stall_at_eop", {31'd0, sr}, 0);
      @(posedge clk); #1;
      chk("free_after_eop", {31'd0, sr}, 1);
      wait_fc(4);
      for (int k = 0; k < 64; k++) put(DW'(1000 + k));
      wait_fc(12);
      for (int i = 0; i < 400; i++) begin
         sv = ($urandom % 4) != 0;
         sd = DW'($urandom);
         rdy = ($urandom % 3) != 0;
         @(posedge clk); #1;
      end
      sv = 0; rdy = 1;
      while (wr_cnt % LEN != 0) put(DW'($urandom));
      t = 0;
      while ((q.size() != 0 || vld) && t < 600) begin
         @(posedge clk); #1; t++;
      end
      chk("drained", q.size(), 0);
      rdy = 0;
      for (int k = 201; k <= 208; k++) put(DW'(k));
      t = 0;
      while (!vld && t < 50) begin
         @(posedge clk); #1; t++;
      end
      rdy = 1;
      t = 0;
      while (!(vld && dat == DW'(204)) && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("bin3_seen", 32'(dat), 204);
      #1 rst_n = 0;
      #1;
      chk("mid_rst_valid", {31'd0, vld}, 0);
      chk("mid_rst_data", 32'(dat), 0);
      chk("mid_rst_sopeop", {30'd0, sop, eop}, 0);
      chk("mid_rst_fc", {16'd0, fc}, 0);
      @(posedge clk); #1;
      rst_n = 1;
      chk("post_rst_ready", {31'd0, sr}, 1);
      for (int k = 301; k <= 308; k++) put(DW'(k));
      wait_fc(1);
      for (int k = 0; k < 16; k++) begin
         sv1 = 1; sd1 = DW'(500 + k);
         @(posedge clk); #1;
      end
      sv1 = 0;
      chk("g0_both_full", {31'd0, sr1}, 0);
      chk("g0_first", {30'd0, vld1, sop1}, 3);
      chk("g0_first_data", 32'(dat1), 500);
      rdy1 = 1;
      t = 0;
      while (!(vld1 && eop1) && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("g0_eop_data", 32'(dat1), 507);
      @(posedge clk); #1;
      t = 0;
      while (!vld1 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      chk("g0_gap", t, 2);
      chk("g0_sop2", {30'd0, vld1, sop1}, 3);
      chk("g0_sop2_data", 32'(dat1), 508);
      chk("g0_fc", {16'd0, fc1}, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("g0_fc2", {16'd0, fc1}, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
